robo_step_scheduler: RTL and testbench

- Sequences the maze-robot pair: decides when Robo takes a decision step and when Memo applies the resulting move.
- Replaces direct clock-domain hopping with one clock plus enables.
- Sits between the user controls (manual_clock button, run/pause) and the Robo/Memo pair.
- Enforces a request/acknowledge handshake with the memory, a step budget and a memory-timeout watchdog.

---
 rtl/robo_sched_pkg.sv | 23 ++
 rtl/btn_conditioner.sv | 64 ++++++
 rtl/robo_step_scheduler.sv | 146 ++++++++++++++
 tb/tb_robo_step_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/robo_sched_pkg.sv
// Shared state encoding and default timing constants for the Robo/Memo step scheduler.
package robo_sched_pkg;

    localparam int unsigned DefRateDiv        = 32'd50_000_000;
    localparam int unsigned DefMaxSteps       = 32'd1023;
    localparam int unsigned DefAckTimeout     = 32'd255;
    localparam int unsigned DefDebounceCycles = 32'd500_000;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StRun       = 3'd1,
        StIssue     = 3'd2,
        StWaitRobot = 3'd3,
        StMemWait   = 3'd4,
        StHalt      = 3'd5,
        StError     = 3'd6
    } sched_state_e;

    function automatic logic state_is_busy(input sched_state_e st);
        return (st == StIssue) || (st == StWaitRobot) || (st == StMemWait);
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Step button conditioning: 2-flop synchroniser, optional debouncer, rising-edge pulse.
// The debouncer is built only when STEP_DEBOUNCE_EN is defined.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_d1;
    logic w_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DbLast = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_stable;
    logic [DB_W-1:0] r_db_cnt;

    // Count consecutive samples that disagree with the stable level; any agreement restarts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync2 == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DbLast) begin
            r_stable <= r_sync2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level_d1 <= 1'b0;
        end else begin
            r_level_d1 <= w_level;
        end
    end

    assign o_pulse = w_level & ~r_level_d1;

endmodule

// File: rtl/robo_step_scheduler.sv
// Single-clock step sequencer for the Robo/Memo pair: manual or rate-driven steps, memory
// handshake with timeout watchdog and step budget. Optional button debounce: STEP_DEBOUNCE_EN.
module robo_step_scheduler
    import robo_sched_pkg::*;
#(
    parameter int unsigned RATE_DIV        = DefRateDiv,
    parameter int unsigned MAX_STEPS       = DefMaxSteps,
    parameter int unsigned ACK_TIMEOUT     = DefAckTimeout,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    localparam int unsigned CNT_W          = $clog2(MAX_STEPS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             manual_clock,
    input  logic             run,
    input  logic             clear,
    input  logic             robot_done,
    input  logic             mem_ack,
    output logic             robot_step,
    output logic             mem_req,
    output logic [CNT_W-1:0] step_count,
    output logic             busy,
    output logic             halted,
    output logic             error
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] MaxCnt   = CNT_W'(MAX_STEPS);
    localparam logic [TMO_W-1:0] TmoLast  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [31:0]      RateLoad = 32'(RATE_DIV - 1);

    sched_state_e     r_state;
    sched_state_e     w_state_next;
    logic [31:0]      r_rate;
    logic [31:0]      w_rate_next;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_btn_pulse;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .i_clk  (clock),
        .i_rst_n(reset),
        .i_btn  (manual_clock),
        .o_pulse(w_btn_pulse)
    );

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_rate_next  = r_rate;
        w_tmo_next   = r_tmo;
        w_cnt_next   = r_cnt;

        unique case (r_state)
            StIdle: begin
                if (run) begin
                    w_rate_next  = RateLoad;
                    w_state_next = StRun;
                end else if (w_btn_pulse) begin
                    w_state_next = StIssue;
                end
            end
            StRun: begin
                if (!run) begin
                    w_rate_next  = '0;
                    w_state_next = StIdle;
                end else if (r_rate == '0) begin
                    w_state_next = StIssue;
                end else begin
                    w_rate_next = r_rate - 1'b1;
                end
            end
            StIssue: begin
                w_state_next = StWaitRobot;
            end
            StWaitRobot: begin
                if (robot_done) begin
                    w_state_next = StHalt;
                end else begin
                    w_tmo_next   = '0;
                    w_state_next = StMemWait;
                end
            end
            StMemWait: begin
                // Ack has priority over the watchdog when both land together.
                if (mem_ack) begin
                    w_cnt_next = w_cnt_inc;
                    if (!clear && (w_cnt_inc == MaxCnt)) begin
                        w_state_next = StHalt;
                    end else if (run) begin
                        w_rate_next  = RateLoad;
                        w_state_next = StRun;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else if (r_tmo == TmoLast) begin
                    w_state_next = StError;
                end else begin
                    w_tmo_next = r_tmo + 1'b1;
                end
            end
            StHalt, StError: begin
                if (clear) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        // A clear always zeroes the count, even against a same-cycle increment.
        if (clear) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_rate  <= '0;
            r_tmo   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_rate  <= w_rate_next;
            r_tmo   <= w_tmo_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign robot_step = (r_state == StIssue);
    assign mem_req    = (r_state == StMemWait);
    assign busy       = state_is_busy(r_state);
    assign halted     = (r_state == StHalt);
    assign error      = (r_state == StError);
    assign step_count = r_cnt;

endmodule

// File: tb/tb_robo_step_scheduler.sv
// Directed self-checking bench for robo_step_scheduler (RATE_DIV=4, MAX_STEPS=3, ACK_TIMEOUT=8).
module tb_robo_step_scheduler;
    import robo_sched_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       manual_clock;
    logic       run;
    logic       clear;
    logic       robot_done;
    logic       ack_manual;
    logic       auto_ack;
    logic       mem_ack;
    logic       robot_step;
    logic       mem_req;
    logic [1:0] step_count;
    logic       busy;
    logic       halted;
    logic       error;

    int total = 0;
    int bad   = 0;
    int n_pulses = 0;

    assign mem_ack = ack_manual | (auto_ack & mem_req);

    robo_step_scheduler #(
        .RATE_DIV       (4),
        .MAX_STEPS      (3),
        .ACK_TIMEOUT    (8),
        .DEBOUNCE_CYCLES(5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .manual_clock(manual_clock),
        .run         (run),
        .clear       (clear),
        .robot_done  (robot_done),
        .mem_ack     (mem_ack),
        .robot_step  (robot_step),
        .mem_req     (mem_req),
        .step_count  (step_count),
        .busy        (busy),
        .halted      (halted),
        .error       (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (robot_step === 1'b1) n_pulses <= n_pulses + 1;
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press();
        manual_clock = 1'b1;
        cycle();
        manual_clock = 1'b0;
    endtask

    task automatic wait_step(input int limit, output bit found, output int n);
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            cycle();
            if (robot_step === 1'b1) begin
                found = 1'b1;
                n = i;
                break;
            end
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        bit found;
        int n;
        int base;
        int exp_bounce;

        reset = 1'b0; manual_clock = 1'b0; run = 1'b0; clear = 1'b0;
        robot_done = 1'b0; ack_manual = 1'b0; auto_ack = 1'b0;
        repeat (3) cycle();
        chk("rst_robot_step", robot_step, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_error", error, 0);
        chk("rst_count", step_count, 0);
        reset = 1'b1;
        cycle();

        // Manual step with ack on the second request cycle
        press();
        wait_step(10, found, n);
        chk("man_found", found, 1);
        chk("man_latency", 1 + n, 3);
        cycle();
        chk("man_wait_robot_noreq", mem_req, 0);
        cycle();
        chk("man_req_c1", mem_req, 1);
        cycle();
        chk("man_req_c2", mem_req, 1);
        ack_manual = 1'b1;
        cycle();
        ack_manual = 1'b0;
        chk("man_req_drop", mem_req, 0);
        chk("man_count", step_count, 1);
        chk("man_idle", 32'(dut.r_state), 32'(StIdle));
        ack_manual = 1'b1;
        cycle();
        ack_manual = 1'b0;
        cycle();
        chk("stray_ack_count", step_count, 1);
        chk("stray_ack_idle", 32'(dut.r_state), 32'(StIdle));
        do_clear();
        chk("idle_clear_count", step_count, 0);

        // Automatic stepping, immediate ack
        auto_ack = 1'b1;
        run = 1'b1;
        wait_step(20, found, n);
        chk("auto_first_found", found, 1);
        chk("auto_first_lat", n, 4 + 1);
        wait_step(20, found, n);
        chk("auto_second_found", found, 1);
        chk("auto_period", n, 4 + 3);
        repeat (4) cycle();
        run = 1'b0;
        wait_step(20, found, n);
        chk("auto_stop_nostep", found, 0);
        chk("auto_count", step_count, 2);
        chk("auto_idle", 32'(dut.r_state), 32'(StIdle));

        // Memory timeout
        auto_ack = 1'b0;
        press();
        wait_step(10, found, n);
        chk("tmo_found", found, 1);
        cycle();
        cycle();
        chk("tmo_req_up", mem_req, 1);
        repeat (7) cycle();
        chk("tmo_not_yet", error, 0);
        chk("tmo_req_still", mem_req, 1);
        cycle();
        chk("tmo_error", error, 1);
        chk("tmo_req_drop", mem_req, 0);
        chk("tmo_count_kept", step_count, 2);
        do_clear();
        chk("tmo_clear_idle", 32'(dut.r_state), 32'(StIdle));
        chk("tmo_clear_error", error, 0);
        chk("tmo_clear_count", step_count, 0);

        // Step budget
        base = n_pulses;
        auto_ack = 1'b1;
        run = 1'b1;
        wait_step(20, found, n);
        chk("bud_s1", n, 5);
        wait_step(20, found, n);
        chk("bud_s2", n, 7);
        wait_step(20, found, n);
        chk("bud_s3", n, 7);
        repeat (3) cycle();
        chk("bud_halted", halted, 1);
        chk("bud_count", step_count, 3);
        chk("bud_busy", busy, 0);
        wait_step(20, found, n);
        chk("bud_run_ignored", found, 0);
        run = 1'b0;
        press();
        wait_step(10, found, n);
        chk("bud_btn_ignored", found, 0);
        chk("bud_still_halted", halted, 1);
        chk("bud_pulses", n_pulses - base, 3);
        do_clear();
        chk("bud_clear_halted", halted, 0);
        chk("bud_clear_count", step_count, 0);

        // Goal reached: halt without memory request
        press();
        wait_step(10, found, n);
        chk("goal_found", found, 1);
        robot_done = 1'b1;
        cycle();
        chk("goal_wait_noreq", mem_req, 0);
        cycle();
        robot_done = 1'b0;
        chk("goal_halted", halted, 1);
        chk("goal_noreq", mem_req, 0);
        chk("goal_count", step_count, 0);
        cycle();
        chk("goal_noreq_later", mem_req, 0);
        do_clear();
        chk("goal_clear_idle", 32'(dut.r_state), 32'(StIdle));

        // Reset mid-handshake
        auto_ack = 1'b0;
        press();
        wait_step(10, found, n);
        cycle();
        cycle();
        chk("rsth_req_up", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rsth_req_drop", mem_req, 0);
        chk("rsth_idle", 32'(dut.r_state), 32'(StIdle));
        chk("rsth_busy", busy, 0);
        cycle();
        reset = 1'b1;
        chk("rsth_count", step_count, 0);

        // Bouncing button: 1,0,1,0 held 4 cycles each, then steady 1
`ifdef STEP_DEBOUNCE_EN
        exp_bounce = 1;
`else
        exp_bounce = 3;
`endif
        auto_ack = 1'b1;
        base = n_pulses;
        for (int k = 0; k < 4; k++) begin
            manual_clock = (k % 2 == 0);
            repeat (4) cycle();
        end
        manual_clock = 1'b1;
        repeat (24) cycle();
        manual_clock = 1'b0;
        repeat (4) cycle();
        chk("bounce_pulses", n_pulses - base, exp_bounce);
        chk("bounce_count", step_count, exp_bounce);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
